branch_checkpoint_table: RTL and testbench

// - Owns per-branch rename checkpoints; feeds branch_misprediction via branch_state_ifc.
// - Allocates an entry when rename processes a branch and records its delay-slot status.
// - Releases the entry when the branch resolves correctly.
// - On a mispredict, frees the mispredicted entry and every younger one, and rewinds write_pointer.

---
 rtl/branch_checkpoint_table.sv | 139 +++++++++++++
 tb/tb_branch_checkpoint_table.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_checkpoint_table.sv
// Ring of per-branch rename checkpoints: allocated at rename, released on correct resolve,
// squashed together with all younger entries on a mispredict.
module branch_checkpoint_table #(
  parameter int unsigned BRANCH_NUM       = 4,
  parameter int unsigned ACTIVE_LIST_SIZE = 64,
  parameter int unsigned PHYS_REG_NUM     = 64,
  parameter int unsigned REG_NUM          = 32,
  localparam int unsigned IDW = $clog2(ACTIVE_LIST_SIZE),
  localparam int unsigned PW  = $clog2(PHYS_REG_NUM),
  localparam int unsigned BW  = $clog2(BRANCH_NUM),
  localparam int unsigned CW  = BW + 1,
  localparam int unsigned MW  = REG_NUM * PW
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       alloc_valid,
  input  logic [IDW-1:0]             alloc_branch_id,
  input  logic [PW-1:0]              alloc_free_head,
  input  logic [MW-1:0]              alloc_rename_buffer,
  input  logic                       ds_valid_in,
  input  logic [IDW-1:0]             ds_branch_id,
  input  logic                       resolve_valid,
  input  logic [IDW-1:0]             resolve_branch_id,
  input  logic                       miss_valid,
  input  logic [IDW-1:0]             miss_branch_id,
  output logic [BRANCH_NUM-1:0]      branch_state_valid,
  output logic [BRANCH_NUM*IDW-1:0]  branch_state_branch_id,
  output logic [BRANCH_NUM*PW-1:0]   branch_state_free_head_pointer,
  output logic [BRANCH_NUM*MW-1:0]   branch_state_rename_buffer,
  output logic [BW-1:0]              branch_state_write_pointer,
  output logic [BRANCH_NUM-1:0]      branch_state_ds_valid,
  output logic                       full,
  output logic [CW-1:0]              count
);

  logic [BRANCH_NUM-1:0] valid_q, valid_d;
  logic [BRANCH_NUM-1:0] ds_q, ds_d;
  logic [BW-1:0]         wp_q, wp_d;
  logic [IDW-1:0]        id_q [BRANCH_NUM];
  logic [PW-1:0]         fh_q [BRANCH_NUM];
  logic [MW-1:0]         map_q [BRANCH_NUM];

  logic [BRANCH_NUM-1:0] res_match, ds_match, squash;
  logic                  miss_hit;
  logic [BW-1:0]         miss_idx;
  logic [BW-1:0]         wp_dist;
  logic                  do_alloc, alloc_ds, freeze;

  assign full     = valid_q[wp_q];
  assign do_alloc = alloc_valid && !full && !miss_valid;
  assign alloc_ds = do_alloc && ds_valid_in && (ds_branch_id == alloc_branch_id);
  // A miss that hits nothing leaves the whole table untouched.
  assign freeze   = miss_valid && !miss_hit;

  always_comb begin
    miss_hit = 1'b0;
    miss_idx = '0;
    for (int i = 0; i < BRANCH_NUM; i++) begin
      res_match[i] = valid_q[i] && (id_q[i] == resolve_branch_id);
      ds_match[i]  = valid_q[i] && (id_q[i] == ds_branch_id);
      if (miss_valid && valid_q[i] && (id_q[i] == miss_branch_id)) begin
        miss_hit = 1'b1;
        miss_idx = BW'(i);
      end
    end
  end

  // Ring distance from the missed slot; a zero distance to write_pointer means a full ring.
  always_comb begin
    wp_dist = wp_q - miss_idx;
    for (int i = 0; i < BRANCH_NUM; i++) begin
      squash[i] = miss_hit && ((wp_dist == '0) || ((BW'(i) - miss_idx) < wp_dist));
    end
  end

  always_comb begin
    valid_d = valid_q;
    ds_d    = ds_q;
    wp_d    = wp_q;
    if (!freeze) begin
      if (do_alloc) begin
        valid_d[wp_q] = 1'b1;
        ds_d[wp_q]    = alloc_ds;
        wp_d          = wp_q + BW'(1);
      end
      for (int i = 0; i < BRANCH_NUM; i++) begin
        if (ds_valid_in && ds_match[i]) ds_d[i] = 1'b1;
        if ((resolve_valid && res_match[i]) || squash[i]) begin
          valid_d[i] = 1'b0;
          ds_d[i]    = 1'b0;
        end
      end
      if (miss_valid) wp_d = miss_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      ds_q    <= '0;
      wp_q    <= '0;
      for (int i = 0; i < BRANCH_NUM; i++) begin
        id_q[i]  <= '0;
        fh_q[i]  <= '0;
        map_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      ds_q    <= ds_d;
      wp_q    <= wp_d;
      if (do_alloc) begin
        id_q[wp_q]  <= alloc_branch_id;
        fh_q[wp_q]  <= alloc_free_head;
        map_q[wp_q] <= alloc_rename_buffer;
      end
    end
  end

  always_comb begin
    count = '0;
    for (int i = 0; i < BRANCH_NUM; i++) begin
      count = count + CW'(valid_q[i]);
      branch_state_branch_id[i*IDW +: IDW]        = id_q[i];
      branch_state_free_head_pointer[i*PW +: PW]  = fh_q[i];
      branch_state_rename_buffer[i*MW +: MW]      = map_q[i];
    end
  end

  assign branch_state_valid         = valid_q;
  assign branch_state_ds_valid      = ds_q;
  assign branch_state_write_pointer = wp_q;

  alloc_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(alloc_valid && full)) else $warning("alloc_when_full: branch alloc dropped");

  miss_no_entry: assert property (@(posedge clk) disable iff (!rst_n)
    !(miss_valid && !miss_hit)) else $warning("miss_no_entry: miss id not in table");

endmodule

// File: tb/tb_branch_checkpoint_table.sv
// Scoreboard bench for branch_checkpoint_table: driver queues expected registered state,
// monitor compares it on the following falling edge.
module tb_branch_checkpoint_table;

  localparam int BN = 4;
  localparam int IDW = 6;
  localparam int PW = 6;
  localparam int RN = 32;
  localparam int MW = RN * PW;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            alloc_valid;
  logic [IDW-1:0]  alloc_branch_id;
  logic [PW-1:0]   alloc_free_head;
  logic [MW-1:0]   alloc_rename_buffer;
  logic            ds_valid_in;
  logic [IDW-1:0]  ds_branch_id;
  logic            resolve_valid;
  logic [IDW-1:0]  resolve_branch_id;
  logic            miss_valid;
  logic [IDW-1:0]  miss_branch_id;
  logic [BN-1:0]     bs_valid;
  logic [BN*IDW-1:0] bs_id;
  logic [BN*PW-1:0]  bs_fh;
  logic [BN*MW-1:0]  bs_map;
  logic [1:0]        bs_wp;
  logic [BN-1:0]     bs_ds;
  logic              full;
  logic [2:0]        count;

  branch_checkpoint_table dut (
    .clk                            (clk),
    .rst_n                          (rst_n),
    .alloc_valid                    (alloc_valid),
    .alloc_branch_id                (alloc_branch_id),
    .alloc_free_head                (alloc_free_head),
    .alloc_rename_buffer            (alloc_rename_buffer),
    .ds_valid_in                    (ds_valid_in),
    .ds_branch_id                   (ds_branch_id),
    .resolve_valid                  (resolve_valid),
    .resolve_branch_id              (resolve_branch_id),
    .miss_valid                     (miss_valid),
    .miss_branch_id                 (miss_branch_id),
    .branch_state_valid             (bs_valid),
    .branch_state_branch_id         (bs_id),
    .branch_state_free_head_pointer (bs_fh),
    .branch_state_rename_buffer     (bs_map),
    .branch_state_write_pointer     (bs_wp),
    .branch_state_ds_valid          (bs_ds),
    .full                           (full),
    .count                          (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] valid;
    logic [3:0] ds;
    logic [1:0] wp;
    logic       full;
    logic [2:0] count;
    logic       chk;
    int         slot;
    logic [5:0] id;
    logic [5:0] fh;
    logic [5:0] r1;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      cmp("valid", 32'(bs_valid), 32'(e.valid));
      cmp("ds_valid", 32'(bs_ds), 32'(e.ds));
      cmp("write_pointer", 32'(bs_wp), 32'(e.wp));
      cmp("full", 32'(full), 32'(e.full));
      cmp("count", 32'(count), 32'(e.count));
      if (e.chk) begin
        cmp("entry_branch_id", 32'(bs_id[e.slot*IDW +: IDW]), 32'(e.id));
        cmp("entry_free_head", 32'(bs_fh[e.slot*PW +: PW]), 32'(e.fh));
        cmp("entry_map_r1", 32'(bs_map[(e.slot*RN + 1)*PW +: PW]), 32'(e.r1));
      end
    end
  end

  function automatic exp_t mk(input logic [3:0] v, input logic [3:0] ds, input logic [1:0] wp,
                              input logic f, input logic [2:0] c);
    exp_t e;
    e.valid = v; e.ds = ds; e.wp = wp; e.full = f; e.count = c;
    e.chk = 1'b0; e.slot = 0; e.id = '0; e.fh = '0; e.r1 = '0;
    return e;
  endfunction

  task automatic idle_inputs();
    alloc_valid = 1'b0; alloc_branch_id = '0; alloc_free_head = '0; alloc_rename_buffer = '0;
    ds_valid_in = 1'b0; ds_branch_id = '0;
    resolve_valid = 1'b0; resolve_branch_id = '0;
    miss_valid = 1'b0; miss_branch_id = '0;
  endtask

  // Inputs already applied; clock them in and queue the state expected afterwards.
  task automatic step(input exp_t e);
    @(posedge clk);
    #1;
    q.push_back(e);
    idle_inputs();
  endtask

  task automatic alloc(input int id, input exp_t e);
    alloc_valid = 1'b1; alloc_branch_id = IDW'(id);
    step(e);
  endtask

  task automatic miss(input int id, input exp_t e);
    miss_valid = 1'b1; miss_branch_id = IDW'(id);
    step(e);
  endtask

  task automatic resolve(input int id, input exp_t e);
    resolve_valid = 1'b1; resolve_branch_id = IDW'(id);
    step(e);
  endtask

  task automatic drain();
    for (int k = 0; k < 10 && q.size() != 0; k++) @(negedge clk);
    #1;
    cmp("scoreboard_drained", 32'(q.size()), 32'd0);
    q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(mk(4'b0000, 4'b0000, 2'd0, 1'b0, 3'd0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, pending=%0d", q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    do_reset();

    alloc(3,  mk(4'b0001, 4'b0000, 2'd1, 1'b0, 3'd1));
    alloc(7,  mk(4'b0011, 4'b0000, 2'd2, 1'b0, 3'd2));
    alloc(12, mk(4'b0111, 4'b0000, 2'd3, 1'b0, 3'd3));
    alloc(20, mk(4'b1111, 4'b0000, 2'd0, 1'b1, 3'd4));
    alloc(30, mk(4'b1111, 4'b0000, 2'd0, 1'b1, 3'd4));
    miss(3,   mk(4'b0000, 4'b0000, 2'd0, 1'b0, 3'd0));

    e = mk(4'b0001, 4'b0000, 2'd1, 1'b0, 3'd1);
    e.chk = 1'b1; e.slot = 0; e.id = 6'd5; e.fh = 6'd9; e.r1 = 6'd40;
    alloc_free_head = 6'd9;
    alloc_rename_buffer[1*PW +: PW] = 6'd40;
    alloc(5, e);
    miss(5,   mk(4'b0000, 4'b0000, 2'd0, 1'b0, 3'd0));

    alloc(3,  mk(4'b0001, 4'b0000, 2'd1, 1'b0, 3'd1));
    alloc(7,  mk(4'b0011, 4'b0000, 2'd2, 1'b0, 3'd2));
    alloc(12, mk(4'b0111, 4'b0000, 2'd3, 1'b0, 3'd3));
    miss(7,   mk(4'b0001, 4'b0000, 2'd1, 1'b0, 3'd1));
    e = mk(4'b0011, 4'b0000, 2'd2, 1'b0, 3'd2);
    e.chk = 1'b1; e.slot = 1; e.id = 6'd25; e.fh = 6'd0; e.r1 = 6'd0;
    alloc(25, e);
    resolve(3,  mk(4'b0010, 4'b0000, 2'd2, 1'b0, 3'd1));
    resolve(25, mk(4'b0000, 4'b0000, 2'd2, 1'b0, 3'd0));
    alloc(40,   mk(4'b0100, 4'b0000, 2'd3, 1'b0, 3'd1));
    resolve(40, mk(4'b0000, 4'b0000, 2'd3, 1'b0, 3'd0));

    alloc(50, mk(4'b1000, 4'b0000, 2'd0, 1'b0, 3'd1));
    alloc(51, mk(4'b1001, 4'b0000, 2'd1, 1'b0, 3'd2));
    alloc(52, mk(4'b1011, 4'b0000, 2'd2, 1'b0, 3'd3));
    miss(50,  mk(4'b0000, 4'b0000, 2'd3, 1'b0, 3'd0));
    drain();

    do_reset();
    alloc(3, mk(4'b0001, 4'b0000, 2'd1, 1'b0, 3'd1));
    alloc_valid = 1'b1; alloc_branch_id = 6'd9;
    miss(3,  mk(4'b0000, 4'b0000, 2'd0, 1'b0, 3'd0));

    ds_valid_in = 1'b1; ds_branch_id = 6'd12;
    alloc(12,   mk(4'b0001, 4'b0001, 2'd1, 1'b0, 3'd1));
    resolve(12, mk(4'b0000, 4'b0000, 2'd1, 1'b0, 3'd0));

    alloc(13, mk(4'b0010, 4'b0000, 2'd2, 1'b0, 3'd1));
    ds_valid_in = 1'b1; ds_branch_id = 6'd13;
    resolve(13, mk(4'b0000, 4'b0000, 2'd2, 1'b0, 3'd0));

    alloc(14, mk(4'b0100, 4'b0000, 2'd3, 1'b0, 3'd1));
    ds_valid_in = 1'b1; ds_branch_id = 6'd14;
    step(mk(4'b0100, 4'b0100, 2'd3, 1'b0, 3'd1));
    alloc(15, mk(4'b1100, 4'b0100, 2'd0, 1'b0, 3'd2));
    resolve_valid = 1'b1; resolve_branch_id = 6'd14;
    miss(15,  mk(4'b0000, 4'b0000, 2'd3, 1'b0, 3'd0));

    alloc(16, mk(4'b1000, 4'b0000, 2'd0, 1'b0, 3'd1));
    alloc(17, mk(4'b1001, 4'b0000, 2'd1, 1'b0, 3'd2));
    ds_valid_in = 1'b1; ds_branch_id = 6'd17;
    miss(16,  mk(4'b0000, 4'b0000, 2'd3, 1'b0, 3'd0));
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
